// File: rtl/ball_collision_arbiter.sv
// ball_collision_arbiter
//   Classifies ball-ball, ball-wall and ball-hole hits for the current pixel,
//   suppresses repeats with per-pair and per-ball frame cooldowns, tracks the
//   balls still on the table, and queues decoded events in a small FIFO that
//   the physics unit drains with a valid/ready handshake.
//
// Ports
//   clk, resetN       pixel clock, synchronous active-low reset
//   startOfFrame      one-cycle frame-start pulse (ages cooldowns, no detection)
//   cheat             keypad level, used only when HIT_CHEAT_EN is defined
//   Table_DR          wall draw request / wall code (non-zero = wall pixel)
//   Balls_DR_VEC      per-ball draw requests
//   Hole_DR           hole draw request
//   evt_ready         consumer accepts the head event
//   evt_valid         queue non-empty
//   evt_type          00 ball-ball, 01 ball-wall, 10 ball-hole
//   evt_id_a/_b       ball indices (a <= b)
//   evt_wall          wall code for ball-wall events
//   balls_in_game     1 = ball still on the table
//   drop_count        saturating count of events lost to a full queue
//   collision         combinational wall or ball-ball overlap flag
//
// Optional feature macro: HIT_CHEAT_EN
//   When defined, a rising edge of cheat removes the lowest-index non-cue
//   ball from balls_in_game.

module ball_collision_arbiter #(
  parameter int NUM_BALLS       = 7,
  parameter int NUM_PAIR_SLOTS  = 3,
  parameter int COOLDOWN_FRAMES = 2,
  parameter int FIFO_DEPTH      = 4,
  localparam int IDW            = $clog2(NUM_BALLS)
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 cheat,
  input  logic [1:0]           Table_DR,
  input  logic [NUM_BALLS-1:0] Balls_DR_VEC,
  input  logic                 Hole_DR,
  input  logic                 evt_ready,
  output logic                 evt_valid,
  output logic [1:0]           evt_type,
  output logic [IDW-1:0]       evt_id_a,
  output logic [IDW-1:0]       evt_id_b,
  output logic [1:0]           evt_wall,
  output logic [NUM_BALLS-1:0] balls_in_game,
  output logic [7:0]           drop_count,
  output logic                 collision
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = (NUM_PAIR_SLOTS > 1) ? $clog2(NUM_PAIR_SLOTS) : 1;

  typedef struct packed {
    logic [1:0]     typ;
    logic [IDW-1:0] id_a;
    logic [IDW-1:0] id_b;
    logic [1:0]     wall;
  } evt_t;

  typedef enum logic [1:0] {K_NONE, K_BH, K_BB, K_BW} kind_t;

  evt_t                 mem_q [FIFO_DEPTH];
  evt_t                 mem_d [FIFO_DEPTH];
  logic [PW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NUM_BALLS-1:0] big_q, big_d;
  logic [7:0]           drop_q, drop_d;
  logic [NUM_PAIR_SLOTS-1:0] slot_act_q, slot_act_d;
  logic [IDW-1:0]       slot_a_q [NUM_PAIR_SLOTS];
  logic [IDW-1:0]       slot_a_d [NUM_PAIR_SLOTS];
  logic [IDW-1:0]       slot_b_q [NUM_PAIR_SLOTS];
  logic [IDW-1:0]       slot_b_d [NUM_PAIR_SLOTS];
  logic [1:0]           slot_cnt_q [NUM_PAIR_SLOTS];
  logic [1:0]           slot_cnt_d [NUM_PAIR_SLOTS];
  logic [NUM_BALLS-1:0] wall_cd_q, wall_cd_d, wall_age_q, wall_age_d;

  logic [IDW:0]         pop_cnt;
  logic [IDW-1:0]       low_idx, high_idx, bh_idx;
  logic                 bh_found;
  logic                 bb_raw, bw_raw, bh_raw;
  logic                 pair_hit, free_found;
  logic [SW-1:0]        free_idx;
  kind_t                kind;
  evt_t                 cand_evt, head;
  logic                 full, pop, push, drop;
  logic [NUM_BALLS-1:0] cheat_clr;

  // Popcount plus lowest/highest requesting ball; the hole target must also
  // still be in game so a removed ball can never fire again.
  always_comb begin
    pop_cnt  = '0;
    low_idx  = '0;
    high_idx = '0;
    bh_idx   = '0;
    bh_found = 1'b0;
    for (int i = NUM_BALLS - 1; i >= 0; i--) begin
      pop_cnt = pop_cnt + (IDW+1)'(Balls_DR_VEC[i]);
      if (Balls_DR_VEC[i]) low_idx = IDW'(i);
      if (Balls_DR_VEC[i] && big_q[i]) begin
        bh_idx   = IDW'(i);
        bh_found = 1'b1;
      end
    end
    for (int i = 0; i < NUM_BALLS; i++) begin
      if (Balls_DR_VEC[i]) high_idx = IDW'(i);
    end
  end

  assign bb_raw    = !startOfFrame && (pop_cnt == (IDW+1)'(2));
  assign bw_raw    = !startOfFrame && (Table_DR != 2'b00) && (pop_cnt == (IDW+1)'(1));
  assign bh_raw    = !startOfFrame && Hole_DR && (pop_cnt != '0);
  assign collision = bb_raw || bw_raw;

  always_comb begin
    pair_hit   = 1'b0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int s = NUM_PAIR_SLOTS - 1; s >= 0; s--) begin
      if (slot_act_q[s] && slot_a_q[s] == low_idx && slot_b_q[s] == high_idx) pair_hit = 1'b1;
      if (!slot_act_q[s]) begin
        free_found = 1'b1;
        free_idx   = SW'(s);
      end
    end
  end

  // Priority is decided on the raw detects: a hole hit with no eligible
  // target still masks the lower-priority detects of that cycle.
  always_comb begin
    kind     = K_NONE;
    cand_evt = '0;
    if (bh_raw) begin
      if (bh_found) begin
        kind     = K_BH;
        cand_evt = '{typ: 2'b10, id_a: bh_idx, id_b: bh_idx, wall: 2'b00};
      end
    end else if (bb_raw) begin
      if (!pair_hit && free_found) begin
        kind     = K_BB;
        cand_evt = '{typ: 2'b00, id_a: low_idx, id_b: high_idx, wall: 2'b00};
      end
    end else if (bw_raw) begin
      if (!wall_cd_q[low_idx]) begin
        kind     = K_BW;
        cand_evt = '{typ: 2'b01, id_a: low_idx, id_b: low_idx, wall: Table_DR};
      end
    end
  end

`ifdef HIT_CHEAT_EN
  logic cheat_q, cheat_d;

  assign cheat_d = cheat;

  always_ff @(posedge clk) begin
    if (!resetN) cheat_q <= 1'b0;
    else         cheat_q <= cheat_d;
  end

  // Cue ball (bit 0) is excluded from the cheat search.
  always_comb begin
    cheat_clr = '0;
    if (cheat && !cheat_q) begin
      for (int i = NUM_BALLS - 1; i >= 1; i--) begin
        if (big_q[i]) begin
          cheat_clr    = '0;
          cheat_clr[i] = 1'b1;
        end
      end
    end
  end
`else
  logic unused_cheat;

  assign unused_cheat = cheat;
  assign cheat_clr    = '0;
`endif

  assign evt_valid = (wr_ptr_q != rd_ptr_q);
  assign full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign pop       = evt_valid && evt_ready;
  // A pop frees the head slot at the same edge, so a full queue still accepts.
  assign push      = (kind != K_NONE) && (!full || pop);
  assign drop      = (kind != K_NONE) && full && !pop;

  // Side effects of an event (slot, cooldown, ball removal) only apply when it
  // is actually queued, so a dropped event is retried on a later pixel.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    big_d      = big_q;
    drop_d     = drop_q;
    slot_act_d = slot_act_q;
    slot_a_d   = slot_a_q;
    slot_b_d   = slot_b_q;
    slot_cnt_d = slot_cnt_q;
    wall_cd_d  = wall_cd_q;
    wall_age_d = wall_age_q;

    if (push) begin
      mem_d[wr_ptr_q[PW-1:0]] = cand_evt;
      wr_ptr_d = wr_ptr_q + (PW+1)'(1);
      case (kind)
        K_BH: if (bh_idx != '0) big_d[bh_idx] = 1'b0;
        K_BB: begin
          slot_act_d[free_idx] = 1'b1;
          slot_a_d[free_idx]   = low_idx;
          slot_b_d[free_idx]   = high_idx;
          slot_cnt_d[free_idx] = 2'd0;
        end
        K_BW: begin
          wall_cd_d[low_idx]  = 1'b1;
          wall_age_d[low_idx] = 1'b0;
        end
        default: ;
      endcase
    end

    if (pop) rd_ptr_d = rd_ptr_q + (PW+1)'(1);

    if (drop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;

    if (startOfFrame) begin
      for (int s = 0; s < NUM_PAIR_SLOTS; s++) begin
        if (slot_act_q[s]) begin
          if (slot_cnt_q[s] == 2'(COOLDOWN_FRAMES - 1)) slot_act_d[s] = 1'b0;
          else                                          slot_cnt_d[s] = slot_cnt_q[s] + 2'd1;
        end
      end
      // First frame start only ages the bit; the second one releases it.
      for (int b = 0; b < NUM_BALLS; b++) begin
        if (wall_cd_q[b]) begin
          if (wall_age_q[b]) begin
            wall_cd_d[b]  = 1'b0;
            wall_age_d[b] = 1'b0;
          end else begin
            wall_age_d[b] = 1'b1;
          end
        end
      end
    end

    big_d = big_d & ~cheat_clr;
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      big_q      <= '1;
      drop_q     <= '0;
      slot_act_q <= '0;
      for (int s = 0; s < NUM_PAIR_SLOTS; s++) begin
        slot_a_q[s]   <= '0;
        slot_b_q[s]   <= '0;
        slot_cnt_q[s] <= '0;
      end
      wall_cd_q  <= '0;
      wall_age_q <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      big_q      <= big_d;
      drop_q     <= drop_d;
      slot_act_q <= slot_act_d;
      slot_a_q   <= slot_a_d;
      slot_b_q   <= slot_b_d;
      slot_cnt_q <= slot_cnt_d;
      wall_cd_q  <= wall_cd_d;
      wall_age_q <= wall_age_d;
    end
  end

  // Head fields read as zero whenever the queue is empty.
  assign head          = mem_q[rd_ptr_q[PW-1:0]];
  assign evt_type      = evt_valid ? head.typ  : 2'b00;
  assign evt_id_a      = evt_valid ? head.id_a : '0;
  assign evt_id_b      = evt_valid ? head.id_b : '0;
  assign evt_wall      = evt_valid ? head.wall : 2'b00;
  assign balls_in_game = big_q;
  assign drop_count    = drop_q;

endmodule

// File: tb/tb_ball_collision_arbiter.sv
// Directed bench for ball_collision_arbiter with default parameters
// (7 balls, 3 pair slots, 2 cooldown frames, 4-deep queue).

module tb_ball_collision_arbiter;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame;
  logic       cheat;
  logic [1:0] Table_DR;
  logic [6:0] Balls_DR_VEC;
  logic       Hole_DR;
  logic       evt_ready;
  logic       evt_valid;
  logic [1:0] evt_type;
  logic [2:0] evt_id_a;
  logic [2:0] evt_id_b;
  logic [1:0] evt_wall;
  logic [6:0] balls_in_game;
  logic [7:0] drop_count;
  logic       collision;

  logic [10:0] head_now;
  int n_checks = 0;
  int n_fail   = 0;

  ball_collision_arbiter dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (startOfFrame),
    .cheat         (cheat),
    .Table_DR      (Table_DR),
    .Balls_DR_VEC  (Balls_DR_VEC),
    .Hole_DR       (Hole_DR),
    .evt_ready     (evt_ready),
    .evt_valid     (evt_valid),
    .evt_type      (evt_type),
    .evt_id_a      (evt_id_a),
    .evt_id_b      (evt_id_b),
    .evt_wall      (evt_wall),
    .balls_in_game (balls_in_game),
    .drop_count    (drop_count),
    .collision     (collision)
  );

  always #5 clk = ~clk;

  assign head_now = {evt_valid, evt_type, evt_id_a, evt_id_b, evt_wall};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic hole, input logic [1:0] tbl, input logic [6:0] balls, input logic rdy);
    Hole_DR      = hole;
    Table_DR     = tbl;
    Balls_DR_VEC = balls;
    evt_ready    = rdy;
    tick();
    Hole_DR      = 1'b0;
    Table_DR     = 2'b00;
    Balls_DR_VEC = '0;
    evt_ready    = 1'b0;
  endtask

  task automatic pop_one();
    drive(1'b0, 2'b00, 7'b0, 1'b1);
  endtask

  task automatic sof_pulse();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic do_reset();
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    cheat        = 1'b0;
    Table_DR     = 2'b00;
    Balls_DR_VEC = '0;
    Hole_DR      = 1'b0;
    evt_ready    = 1'b0;
    tick();
    tick();
    resetN = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (head_now !== 11'h000) begin
      n_fail++;
      $display("[TB] FAIL reset_head: got %h expected %h", head_now, 11'h000);
    end
    n_checks++;
    if (balls_in_game !== 7'h7F) begin
      n_fail++;
      $display("[TB] FAIL reset_balls: got %b expected %b", balls_in_game, 7'h7F);
    end
    n_checks++;
    if (drop_count !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_drop: got %0d expected 0", drop_count);
    end
    n_checks++;
    if (collision !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_collision: got %b expected 0", collision);
    end
  endtask

  task automatic test_ball_ball();
    do_reset();
    Balls_DR_VEC = 7'b0000110;
    #1;
    n_checks++;
    if (collision !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL bb_collision: got %b expected 1", collision);
    end
    @(posedge clk);
    #1;
    Balls_DR_VEC = '0;
    n_checks++;
    if (head_now !== {1'b1, 2'b00, 3'd1, 3'd2, 2'b00}) begin
      n_fail++;
      $display("[TB] FAIL bb_first: got %h expected %h", head_now, {1'b1, 2'b00, 3'd1, 3'd2, 2'b00});
    end
    pop_one();
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bb_popped: got %b expected 0", evt_valid);
    end
    drive(1'b0, 2'b00, 7'b0000110, 1'b0);
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bb_same_frame: got %b expected 0", evt_valid);
    end
    sof_pulse();
    drive(1'b0, 2'b00, 7'b0000110, 1'b0);
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bb_next_frame: got %b expected 0", evt_valid);
    end
    sof_pulse();
    drive(1'b0, 2'b00, 7'b0000110, 1'b0);
    n_checks++;
    if (head_now !== {1'b1, 2'b00, 3'd1, 3'd2, 2'b00}) begin
      n_fail++;
      $display("[TB] FAIL bb_after_cooldown: got %h expected %h", head_now, {1'b1, 2'b00, 3'd1, 3'd2, 2'b00});
    end
  endtask

  task automatic test_pair_slots();
    do_reset();
    drive(1'b0, 2'b00, 7'b0000110, 1'b0);
    drive(1'b0, 2'b00, 7'b0011000, 1'b0);
    drive(1'b0, 2'b00, 7'b1100000, 1'b0);
    drive(1'b0, 2'b00, 7'b0000011, 1'b0);
    n_checks++;
    if (head_now !== {1'b1, 2'b00, 3'd1, 3'd2, 2'b00}) begin
      n_fail++;
      $display("[TB] FAIL slots_head0: got %h expected %h", head_now, {1'b1, 2'b00, 3'd1, 3'd2, 2'b00});
    end
    pop_one();
    n_checks++;
    if (head_now !== {1'b1, 2'b00, 3'd3, 3'd4, 2'b00}) begin
      n_fail++;
      $display("[TB] FAIL slots_head1: got %h expected %h", head_now, {1'b1, 2'b00, 3'd3, 3'd4, 2'b00});
    end
    pop_one();
    n_checks++;
    if (head_now !== {1'b1, 2'b00, 3'd5, 3'd6, 2'b00}) begin
      n_fail++;
      $display("[TB] FAIL slots_head2: got %h expected %h", head_now, {1'b1, 2'b00, 3'd5, 3'd6, 2'b00});
    end
    pop_one();
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL slots_fourth_suppressed: got %b expected 0", evt_valid);
    end
    n_checks++;
    if (drop_count !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL slots_drop: got %0d expected 0", drop_count);
    end
  endtask

  task automatic test_ball_wall();
    do_reset();
    drive(1'b0, 2'b10, 7'b0001000, 1'b0);
    n_checks++;
    if (head_now !== {1'b1, 2'b01, 3'd3, 3'd3, 2'b10}) begin
      n_fail++;
      $display("[TB] FAIL bw_first: got %h expected %h", head_now, {1'b1, 2'b01, 3'd3, 3'd3, 2'b10});
    end
    pop_one();
    drive(1'b0, 2'b10, 7'b0001000, 1'b0);
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bw_same_frame: got %b expected 0", evt_valid);
    end
    sof_pulse();
    drive(1'b0, 2'b10, 7'b0001000, 1'b0);
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bw_one_frame: got %b expected 0", evt_valid);
    end
    sof_pulse();
    drive(1'b0, 2'b10, 7'b0001000, 1'b0);
    n_checks++;
    if (head_now !== {1'b1, 2'b01, 3'd3, 3'd3, 2'b10}) begin
      n_fail++;
      $display("[TB] FAIL bw_two_frames: got %h expected %h", head_now, {1'b1, 2'b01, 3'd3, 3'd3, 2'b10});
    end
  endtask

  task automatic test_ball_hole();
    do_reset();
    drive(1'b1, 2'b00, 7'b0100001, 1'b0);
    n_checks++;
    if (head_now !== {1'b1, 2'b10, 3'd0, 3'd0, 2'b00}) begin
      n_fail++;
      $display("[TB] FAIL bh_cue: got %h expected %h", head_now, {1'b1, 2'b10, 3'd0, 3'd0, 2'b00});
    end
    n_checks++;
    if (balls_in_game !== 7'b1111111) begin
      n_fail++;
      $display("[TB] FAIL bh_cue_kept: got %b expected 1111111", balls_in_game);
    end
    pop_one();
    drive(1'b1, 2'b00, 7'b0100000, 1'b0);
    n_checks++;
    if (head_now !== {1'b1, 2'b10, 3'd5, 3'd5, 2'b00}) begin
      n_fail++;
      $display("[TB] FAIL bh_ball5: got %h expected %h", head_now, {1'b1, 2'b10, 3'd5, 3'd5, 2'b00});
    end
    n_checks++;
    if (balls_in_game !== 7'b1011111) begin
      n_fail++;
      $display("[TB] FAIL bh_ball5_removed: got %b expected 1011111", balls_in_game);
    end
    pop_one();
    drive(1'b1, 2'b00, 7'b0000110, 1'b0);
    n_checks++;
    if (head_now !== {1'b1, 2'b10, 3'd1, 3'd1, 2'b00}) begin
      n_fail++;
      $display("[TB] FAIL bh_over_bb: got %h expected %h", head_now, {1'b1, 2'b10, 3'd1, 3'd1, 2'b00});
    end
    n_checks++;
    if (balls_in_game !== 7'b1011101) begin
      n_fail++;
      $display("[TB] FAIL bh_over_bb_balls: got %b expected 1011101", balls_in_game);
    end
    pop_one();
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bh_only_one: got %b expected 0", evt_valid);
    end
    drive(1'b0, 2'b00, 7'b0000110, 1'b0);
    n_checks++;
    if (head_now !== {1'b1, 2'b00, 3'd1, 3'd2, 2'b00}) begin
      n_fail++;
      $display("[TB] FAIL bh_bb_slot_free: got %h expected %h", head_now, {1'b1, 2'b00, 3'd1, 3'd2, 2'b00});
    end
  endtask

  task automatic test_fifo_full();
    logic [6:0] onehot;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      onehot = 7'd1 << i;
      drive(1'b0, 2'b01, onehot, 1'b0);
    end
    n_checks++;
    if (drop_count !== 8'd1) begin
      n_fail++;
      $display("[TB] FAIL full_drop_count: got %0d expected 1", drop_count);
    end
    n_checks++;
    if (head_now !== {1'b1, 2'b01, 3'd1, 3'd1, 2'b01}) begin
      n_fail++;
      $display("[TB] FAIL full_head: got %h expected %h", head_now, {1'b1, 2'b01, 3'd1, 3'd1, 2'b01});
    end
    drive(1'b0, 2'b01, 7'b0100000, 1'b1);
    n_checks++;
    if (drop_count !== 8'd1) begin
      n_fail++;
      $display("[TB] FAIL full_pushpop_drop: got %0d expected 1", drop_count);
    end
    for (int i = 2; i <= 5; i++) begin
      n_checks++;
      if (head_now !== {1'b1, 2'b01, 3'(i), 3'(i), 2'b01}) begin
        n_fail++;
        $display("[TB] FAIL full_drain_%0d: got %h expected %h", i, head_now, {1'b1, 2'b01, 3'(i), 3'(i), 2'b01});
      end
      pop_one();
    end
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL full_empty: got %b expected 0", evt_valid);
    end
  endtask

  task automatic test_cheat();
    logic [6:0] exp_balls;
`ifdef HIT_CHEAT_EN
    exp_balls = 7'b1111101;
`else
    exp_balls = 7'b1111111;
`endif
    do_reset();
    cheat = 1'b1;
    tick();
    tick();
    cheat = 1'b0;
    tick();
    n_checks++;
    if (balls_in_game !== exp_balls) begin
      n_fail++;
      $display("[TB] FAIL cheat_balls: got %b expected %b", balls_in_game, exp_balls);
    end
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL cheat_no_event: got %b expected 0", evt_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b1, 2'b00, 7'b0000100, 1'b0);
    n_checks++;
    if (evt_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL mid_queued: got %b expected 1", evt_valid);
    end
    resetN = 1'b0;
    tick();
    n_checks++;
    if (head_now !== 11'h000) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_head: got %h expected %h", head_now, 11'h000);
    end
    n_checks++;
    if (balls_in_game !== 7'h7F) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_balls: got %b expected 1111111", balls_in_game);
    end
    resetN = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_ball_ball();
    test_pair_slots();
    test_ball_wall();
    test_ball_hole();
    test_fifo_full();
    test_cheat();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
